// File: rtl/fp_butterfly_addsub_seq_if.sv
// Butterfly sequencer bus: operand input handshake, result output handshake and the
// operand/mode/result ports of the shared floating-point add/sub unit.
interface fp_butterfly_addsub_seq_if #(
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      a_re;
    logic [31:0]      a_im;
    logic [31:0]      b_re;
    logic [31:0]      b_im;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      y0_re;
    logic [31:0]      y0_im;
    logic [31:0]      y1_re;
    logic [31:0]      y1_im;
    logic [31:0]      fu_a;
    logic [31:0]      fu_b;
    logic             fu_sub;
    logic [31:0]      fu_result;
    logic             busy;
    logic [CNT_W-1:0] done_count;

    modport master (
        output in_valid, a_re, a_im, b_re, b_im, out_ready, fu_result,
        input  in_ready, out_valid, y0_re, y0_im, y1_re, y1_im, fu_a, fu_b, fu_sub, busy,
               done_count
    );

    modport slave (
        input  in_valid, a_re, a_im, b_re, b_im, out_ready, fu_result,
        output in_ready, out_valid, y0_re, y0_im, y1_re, y1_im, fu_a, fu_b, fu_sub, busy,
               done_count
    );
endinterface

// File: rtl/fp_butterfly_addsub_seq.sv
// Radix-2 butterfly sequencer: Y0 = A + B, Y1 = A - B time-shared over one FP add/sub unit.
// Define FP_ADDSUB_PIPE_EN when the shared unit registers its result (one cycle late).
module fp_butterfly_addsub_seq #(
    parameter int unsigned CNT_W = 16
) (
    input logic                      clk,
    input logic                      rst_n,
    fp_butterfly_addsub_seq_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StOp0,
        StOp1,
        StOp2,
        StOp3,
        StDrain,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      a_re_q, a_im_q, b_re_q, b_im_q;
    logic [31:0]      y_q [4];  // y0_re, y0_im, y1_re, y1_im
    logic [CNT_W-1:0] done_count_q;

    logic        in_ready;
    logic        accept;
    logic        handshake;
    logic        cap_en;
    logic [1:0]  cap_idx;
    logic [31:0] fu_a;
    logic [31:0] fu_b;
    logic        fu_sub;

    assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & bus.out_ready);
    assign accept    = bus.in_valid & in_ready;
    assign handshake = (state_q == StDone) & bus.out_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StOp0;
            StOp0:   state_d = StOp1;
            StOp1:   state_d = StOp2;
            StOp2:   state_d = StOp3;
`ifdef FP_ADDSUB_PIPE_EN
            StOp3:   state_d = StDrain;
            StDrain: state_d = StDone;
`else
            StOp3:   state_d = StDone;
`endif
            StDone:  if (handshake) state_d = accept ? StOp0 : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fu_a   = '0;
        fu_b   = '0;
        fu_sub = 1'b0;
        unique case (state_q)
            StOp0: begin fu_a = a_re_q; fu_b = b_re_q; end
            StOp1: begin fu_a = a_im_q; fu_b = b_im_q; end
            StOp2: begin fu_a = a_re_q; fu_b = b_re_q; fu_sub = 1'b1; end
            StOp3: begin fu_a = a_im_q; fu_b = b_im_q; fu_sub = 1'b1; end
            default: ;
        endcase
    end

    // Result capture trails the issuing op by one state when the unit is registered.
    always_comb begin
        cap_en  = 1'b0;
        cap_idx = 2'd0;
        unique case (state_q)
`ifdef FP_ADDSUB_PIPE_EN
            StOp1:   begin cap_en = 1'b1; cap_idx = 2'd0; end
            StOp2:   begin cap_en = 1'b1; cap_idx = 2'd1; end
            StOp3:   begin cap_en = 1'b1; cap_idx = 2'd2; end
            StDrain: begin cap_en = 1'b1; cap_idx = 2'd3; end
`else
            StOp0:   begin cap_en = 1'b1; cap_idx = 2'd0; end
            StOp1:   begin cap_en = 1'b1; cap_idx = 2'd1; end
            StOp2:   begin cap_en = 1'b1; cap_idx = 2'd2; end
            StOp3:   begin cap_en = 1'b1; cap_idx = 2'd3; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_re_q <= '0;
            a_im_q <= '0;
            b_re_q <= '0;
            b_im_q <= '0;
        end else if (accept) begin
            a_re_q <= bus.a_re;
            a_im_q <= bus.a_im;
            b_re_q <= bus.b_re;
            b_im_q <= bus.b_im;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) y_q[i] <= '0;
        end else if (cap_en) begin
            y_q[cap_idx] <= bus.fu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_count_q <= '0;
        end else if (handshake) begin
            done_count_q <= done_count_q + 1'b1;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state_q == StDone);
    assign bus.busy       = (state_q != StIdle);
    assign bus.y0_re      = y_q[0];
    assign bus.y0_im      = y_q[1];
    assign bus.y1_re      = y_q[2];
    assign bus.y1_im      = y_q[3];
    assign bus.fu_a       = fu_a;
    assign bus.fu_b       = fu_b;
    assign bus.fu_sub     = fu_sub;
    assign bus.done_count = done_count_q;

endmodule

// File: tb/tb_fp_butterfly_addsub_seq.sv
// Directed bench for fp_butterfly_addsub_seq; the shared add/sub unit is a lookup table
// of hand-computed single-precision results for the vectors used here.
module tb_fp_butterfly_addsub_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_butterfly_addsub_seq_if #(.CNT_W(16)) bus16 ();
    fp_butterfly_addsub_seq_if #(.CNT_W(2))  bus2 ();

    fp_butterfly_addsub_seq #(.CNT_W(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    fp_butterfly_addsub_seq #(.CNT_W(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // Narrow-counter instance sees the same stimulus.
    assign bus2.in_valid  = bus16.in_valid;
    assign bus2.out_ready = bus16.out_ready;
    assign bus2.a_re      = bus16.a_re;
    assign bus2.a_im      = bus16.a_im;
    assign bus2.b_re      = bus16.b_re;
    assign bus2.b_im      = bus16.b_im;

    function automatic logic [31:0] fu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic sub);
        case ({sub, a, b})
            {1'b0, 32'h3F800000, 32'h3F000000}: return 32'h3FC00000; // 1 + 0.5
            {1'b0, 32'h40000000, 32'h3E800000}: return 32'h40100000; // 2 + 0.25
            {1'b1, 32'h3F800000, 32'h3F000000}: return 32'h3F000000; // 1 - 0.5
            {1'b1, 32'h40000000, 32'h3E800000}: return 32'h3FE00000; // 2 - 0.25
            {1'b0, 32'h40400000, 32'h3F800000}: return 32'h40800000; // 3 + 1
            {1'b1, 32'h40400000, 32'h3F800000}: return 32'h40000000; // 3 - 1
            {1'b0, 32'h40000000, 32'h40000000}: return 32'h40800000; // 2 + 2
            {1'b1, 32'h40000000, 32'h40000000}: return 32'h00000000; // 2 - 2
            {1'b0, 32'h40800000, 32'h3F800000}: return 32'h40A00000; // 4 + 1
            {1'b1, 32'h40800000, 32'h3F800000}: return 32'h40400000; // 4 - 1
            {1'b0, 32'h00000000, 32'h00000000}: return 32'h00000000;
            default:                            return 32'hDEADBEEF;
        endcase
    endfunction

`ifdef FP_ADDSUB_PIPE_EN
    localparam int Lat = 5;
    logic [31:0] fu16_q, fu2_q;
    always @(posedge clk) begin
        fu16_q <= fu_model(bus16.fu_a, bus16.fu_b, bus16.fu_sub);
        fu2_q  <= fu_model(bus2.fu_a, bus2.fu_b, bus2.fu_sub);
    end
    assign bus16.fu_result = fu16_q;
    assign bus2.fu_result  = fu2_q;
`else
    localparam int Lat = 4;
    assign bus16.fu_result = fu_model(bus16.fu_a, bus16.fu_b, bus16.fu_sub);
    assign bus2.fu_result  = fu_model(bus2.fu_a, bus2.fu_b, bus2.fu_sub);
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // vec: a_re, a_im, b_re, b_im; expv: y0_re, y0_im, y1_re, y1_im
    logic [31:0] vec  [3][4];
    logic [31:0] expv [3][4];

    wire [127:0] y16 = {bus16.y0_re, bus16.y0_im, bus16.y1_re, bus16.y1_im};
    wire [127:0] y2  = {bus2.y0_re, bus2.y0_im, bus2.y1_re, bus2.y1_im};
    wire [64:0]  fu16 = {bus16.fu_a, bus16.fu_b, bus16.fu_sub};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i);
        bus16.a_re = vec[i][0];
        bus16.a_im = vec[i][1];
        bus16.b_re = vec[i][2];
        bus16.b_im = vec[i][3];
    endtask

    function automatic logic [127:0] exp_y(input int i);
        return {expv[i][0], expv[i][1], expv[i][2], expv[i][3]};
    endfunction

    task automatic wait_out_valid(output int cyc);
        cyc = 0;
        while (!bus16.out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b0;
        bus16.a_re = '0; bus16.a_im = '0; bus16.b_re = '0; bus16.b_im = '0;
        #12;
        n_checks++;
        if (bus16.out_valid !== 1'b0 || bus16.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid_busy: got %b%b want 00", bus16.out_valid, bus16.busy);
        end
        n_checks++;
        if (bus16.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", bus16.in_ready);
        end
        n_checks++;
        if (y16 !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_y: got %h want 0", y16);
        end
        n_checks++;
        if (fu16 !== 65'd0) begin
            n_fail++;
            $display("FAIL reset_fu: got %h want 0", fu16);
        end
        n_checks++;
        if (bus16.done_count !== 16'd0 || bus2.done_count !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_done_count: got %0d/%0d want 0/0", bus16.done_count,
                     bus2.done_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [64:0] exp_fu;
        set_vec(0);
        bus16.in_valid  = 1'b1;
        bus16.out_ready = 1'b0;
        n_checks++;
        if (bus16.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_in_ready_idle: got %b want 1", bus16.in_ready);
        end
        tick();
        bus16.in_valid = 1'b0;
        bus16.a_re = 32'hFFFFFFFF; bus16.a_im = 32'hFFFFFFFF;
        bus16.b_re = 32'hFFFFFFFF; bus16.b_im = 32'hFFFFFFFF;
        for (int k = 0; k < 4; k++) begin
            exp_fu = {(k % 2 == 1) ? vec[0][1] : vec[0][0],
                      (k % 2 == 1) ? vec[0][3] : vec[0][2], (k >= 2) ? 1'b1 : 1'b0};
            n_checks++;
            if (fu16 !== exp_fu) begin
                n_fail++;
                $display("FAIL basic_fu_op%0d: got %h want %h", k, fu16, exp_fu);
            end
            n_checks++;
            if (bus16.out_valid !== 1'b0 || bus16.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_op%0d_valid_busy: got %b%b want 01", k, bus16.out_valid,
                         bus16.busy);
            end
            tick();
        end
`ifdef FP_ADDSUB_PIPE_EN
        n_checks++;
        if (fu16 !== 65'd0 || bus16.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain: got fu %h valid %b want 0 0", fu16, bus16.out_valid);
        end
        tick();
`endif
        n_checks++;
        if (bus16.out_valid !== 1'b1 || bus16.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_valid_ready: got %b%b want 10", bus16.out_valid,
                     bus16.in_ready);
        end
        n_checks++;
        if (y16 !== exp_y(0)) begin
            n_fail++;
            $display("FAIL basic_y: got %h want %h", y16, exp_y(0));
        end
        bus16.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus16.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_in_ready_bypass: got %b want 1", bus16.in_ready);
        end
        tick();
        bus16.out_ready = 1'b0;
        n_checks++;
        if (bus16.done_count !== 16'd1 || bus16.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after_hs: got count %0d busy %b want 1 0", bus16.done_count,
                     bus16.busy);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        set_vec(1);
        bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        wait_out_valid(cyc);
        n_checks++;
        if (bus16.out_valid !== 1'b1 || cyc != Lat) begin
            n_fail++;
            $display("FAIL bp_latency: got valid %b after %0d want 1 after %0d",
                     bus16.out_valid, cyc, Lat);
        end
        for (int i = 0; i < 10; i++) begin
            bus16.in_valid = (i % 2 == 0);
            set_vec(2);
            #1;
            n_checks++;
            if (y16 !== exp_y(1) || bus16.in_ready !== 1'b0 || bus16.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got y %h rdy %b vld %b want %h 0 1", i, y16,
                         bus16.in_ready, bus16.out_valid, exp_y(1));
            end
            tick();
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        tick();
        n_checks++;
        if (bus16.done_count !== 16'd2 || bus16.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got count %0d busy %b want 2 0", bus16.done_count,
                     bus16.busy);
        end
        tick(); tick(); tick();
        n_checks++;
        if (bus16.done_count !== 16'd2) begin
            n_fail++;
            $display("FAIL bp_single_hs: got count %0d want 2", bus16.done_count);
        end
        bus16.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int hs  = 0;
        int cyc = 0;
        int hs_cyc [3];
        bit take;
        for (int i = 0; i < 3; i++) hs_cyc[i] = 0;
        bus16.out_ready = 1'b1;
        set_vec(0);
        bus16.in_valid = 1'b1;
        while (hs < 3 && cyc < 60) begin
            if (bus16.out_valid) begin
                n_checks++;
                if (y16 !== exp_y(hs)) begin
                    n_fail++;
                    $display("FAIL b2b_y%0d: got %h want %h", hs, y16, exp_y(hs));
                end
                hs_cyc[hs] = cyc;
                hs++;
            end
            take = bus16.in_valid && bus16.in_ready;
            tick();
            cyc++;
            if (take) begin
                acc++;
                if (acc < 3) set_vec(acc);
                else bus16.in_valid = 1'b0;
            end
        end
        n_checks++;
        if (hs != 3 || acc != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d handshakes %0d accepts want 3 3", hs, acc);
        end
        n_checks++;
        if (hs_cyc[1] - hs_cyc[0] != Lat + 1 || hs_cyc[2] - hs_cyc[1] != Lat + 1) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d,%0d want %0d", hs_cyc[1] - hs_cyc[0],
                     hs_cyc[2] - hs_cyc[1], Lat + 1);
        end
        n_checks++;
        if (bus16.done_count !== 16'd5) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d want 5", bus16.done_count);
        end
        bus16.out_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        set_vec(2);
        bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        tick(); tick();
        n_checks++;
        if (fu16 !== {vec[2][0], vec[2][2], 1'b1}) begin
            n_fail++;
            $display("FAIL rmid_in_op2: got %h want %h", fu16, {vec[2][0], vec[2][2], 1'b1});
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus16.out_valid !== 1'b0 || bus16.busy !== 1'b0 || y16 !== 128'd0 ||
            bus16.done_count !== 16'd0 || fu16 !== 65'd0 || bus16.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_abort: got vld %b busy %b y %h cnt %0d fu %h rdy %b want all 0 rdy 1",
                     bus16.out_valid, bus16.busy, y16, bus16.done_count, fu16, bus16.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_vec(2);
        bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        wait_out_valid(cyc);
        n_checks++;
        if (bus16.out_valid !== 1'b1 || y16 !== exp_y(2)) begin
            n_fail++;
            $display("FAIL rmid_rerun_y: got vld %b y %h want 1 %h", bus16.out_valid, y16,
                     exp_y(2));
        end
        bus16.out_ready = 1'b1;
        tick();
        bus16.out_ready = 1'b0;
        n_checks++;
        if (bus16.done_count !== 16'd1) begin
            n_fail++;
            $display("FAIL rmid_rerun_count: got %0d want 1", bus16.done_count);
        end
    endtask

    task automatic test_counter_wrap();
        int cyc;
        int wrap_exp [5] = '{1, 2, 3, 0, 1};
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_vec(i % 3);
            bus16.in_valid = 1'b1;
            tick();
            bus16.in_valid = 1'b0;
            wait_out_valid(cyc);
            n_checks++;
            if (bus16.out_valid !== 1'b1 || y2 !== exp_y(i % 3)) begin
                n_fail++;
                $display("FAIL wrap_y%0d: got vld %b y %h want 1 %h", i, bus16.out_valid, y2,
                         exp_y(i % 3));
            end
            tick();
            n_checks++;
            if (int'(bus2.done_count) != wrap_exp[i] || int'(bus16.done_count) != i + 1) begin
                n_fail++;
                $display("FAIL wrap_count%0d: got %0d/%0d want %0d/%0d", i, bus2.done_count,
                         bus16.done_count, wrap_exp[i], i + 1);
            end
        end
        bus16.out_ready = 1'b0;
    endtask

    initial begin
        vec[0]  = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3E800000};
        expv[0] = '{32'h3FC00000, 32'h40100000, 32'h3F000000, 32'h3FE00000};
        vec[1]  = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F000000};
        expv[1] = '{32'h40800000, 32'h3FC00000, 32'h40000000, 32'h3F000000};
        vec[2]  = '{32'h40000000, 32'h40800000, 32'h40000000, 32'h3F800000};
        expv[2] = '{32'h40800000, 32'h40A00000, 32'h00000000, 32'h40400000};

        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_counter_wrap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
